// File: rtl/rtmc_reg_arb.sv
// ---------------------------------------------------------------------------
// rtmc_reg_arb
// Two-requester arbiter/sequencer for the rtmc register bus. Requester 0
// (SPI slave) and requester 1 (command sequencer) share one register target
// port. Transactions are serialised with round-robin fairness; a watchdog
// forces completion when the target never acknowledges.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m0_*/m1_*                requester ports (addr, wdat, wr, rd in;
//                            rdat, ack out)
//   reg_addr/wdat/wr/rd      target request, held until reg_ack sampled
//   reg_rdat, reg_ack        target response
//   gnt                      one-hot current owner, 00 when idle
//   err                      sticky timeout flag, err_clr clears it
// ---------------------------------------------------------------------------
package rtmc_pkg;
   parameter int ADDR_W = 8;
   parameter int DATA_W = 8;
endpackage

module rtmc_reg_arb #(
   parameter int ADDR_W  = rtmc_pkg::ADDR_W,
   parameter int DATA_W  = rtmc_pkg::DATA_W,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdat,
   input  logic              m0_wr,
   input  logic              m0_rd,
   output logic [DATA_W-1:0] m0_rdat,
   output logic              m0_ack,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdat,
   input  logic              m1_wr,
   input  logic              m1_rd,
   output logic [DATA_W-1:0] m1_rdat,
   output logic              m1_ack,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdat,
   output logic              reg_wr,
   output logic              reg_rd,
   input  logic [DATA_W-1:0] reg_rdat,
   input  logic              reg_ack,
   output logic [1:0]        gnt,
   output logic              err,
   input  logic              err_clr
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic              last_m1;
   logic [7:0]        cnt;

   logic              m0_act;
   logic              m1_act;
   logic              pick_m1;
   logic              timeout_hit;
   logic              finish;

   logic [ADDR_W-1:0] reg_addr_d;
   logic [DATA_W-1:0] reg_wdat_d;
   logic              reg_wr_d;
   logic              reg_rd_d;
   logic [1:0]        gnt_d;
   logic              last_m1_d;
   logic [7:0]        cnt_d;
   logic              m0_ack_d;
   logic              m1_ack_d;
   logic [DATA_W-1:0] m0_rdat_d;
   logic [DATA_W-1:0] m1_rdat_d;
   logic              err_d;
   logic [DATA_W-1:0] rdat_ret;

   // Request decode. With both active, the requester that did not win last
   // time is picked; last_m1 resets to 1 so m0 wins the first contention.
   always_comb begin
      m0_act      = m0_wr | m0_rd;
      m1_act      = m1_wr | m1_rd;
      pick_m1     = m1_act & (~m0_act | ~last_m1);
      timeout_hit = (cnt == 8'(TIMEOUT - 1));
      finish      = reg_ack | timeout_hit;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (m0_act | m1_act) state_nxt = BUSY;
         BUSY:    if (finish)          state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values of every registered output. Acks and return data default to
   // zero so they pulse for exactly the one completion cycle; the target
   // request and grant hold unless changed. A real ack beats a coinciding
   // timeout, and a timeout setting err beats err_clr.
   always_comb begin
      reg_addr_d = reg_addr;
      reg_wdat_d = reg_wdat;
      reg_wr_d   = reg_wr;
      reg_rd_d   = reg_rd;
      gnt_d      = gnt;
      last_m1_d  = last_m1;
      cnt_d      = cnt;
      m0_ack_d   = 1'b0;
      m1_ack_d   = 1'b0;
      m0_rdat_d  = '0;
      m1_rdat_d  = '0;
      err_d      = err_clr ? 1'b0 : err;
      rdat_ret   = '0;
      case (state)
         IDLE: begin
            if (m0_act | m1_act) begin
               reg_addr_d = pick_m1 ? m1_addr : m0_addr;
               reg_wdat_d = pick_m1 ? m1_wdat : m0_wdat;
               reg_wr_d   = pick_m1 ? m1_wr : m0_wr;
               reg_rd_d   = pick_m1 ? (m1_rd & ~m1_wr) : (m0_rd & ~m0_wr);
               gnt_d      = pick_m1 ? 2'b10 : 2'b01;
               last_m1_d  = pick_m1;
               cnt_d      = '0;
            end
         end
         BUSY: begin
            cnt_d = cnt + 8'd1;
            if (finish) begin
               reg_wr_d = 1'b0;
               reg_rd_d = 1'b0;
               if (reg_ack) begin
                  rdat_ret = reg_rd ? reg_rdat : '0;
               end else begin
                  rdat_ret = '1;
                  err_d    = 1'b1;
               end
               m0_ack_d  = gnt[0];
               m1_ack_d  = gnt[1];
               m0_rdat_d = gnt[0] ? rdat_ret : '0;
               m1_rdat_d = gnt[1] ? rdat_ret : '0;
            end
         end
         DONE: begin
            gnt_d = 2'b00;
         end
         default: begin
            gnt_d = 2'b00;
         end
      endcase
   end

   // Output and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_addr <= '0;
         reg_wdat <= '0;
         reg_wr   <= 1'b0;
         reg_rd   <= 1'b0;
         gnt      <= 2'b00;
         last_m1  <= 1'b1;
         cnt      <= '0;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         m0_rdat  <= '0;
         m1_rdat  <= '0;
         err      <= 1'b0;
      end else begin
         reg_addr <= reg_addr_d;
         reg_wdat <= reg_wdat_d;
         reg_wr   <= reg_wr_d;
         reg_rd   <= reg_rd_d;
         gnt      <= gnt_d;
         last_m1  <= last_m1_d;
         cnt      <= cnt_d;
         m0_ack   <= m0_ack_d;
         m1_ack   <= m1_ack_d;
         m0_rdat  <= m0_rdat_d;
         m1_rdat  <= m1_rdat_d;
         err      <= err_d;
      end
   end

endmodule

// File: tb/tb_rtmc_reg_arb.sv
// ---------------------------------------------------------------------------
// tb_rtmc_reg_arb
// Directed self-checking bench for rtmc_reg_arb (8-bit address/data,
// TIMEOUT=16). Inputs are driven and outputs sampled on the falling edge.
// The target model acks combinationally while a strobe is up when ack_en is
// set; otherwise reg_ack follows force_ack.
// ---------------------------------------------------------------------------
module tb_rtmc_reg_arb;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] m0_addr, m0_wdat, m0_rdat;
   logic       m0_wr, m0_rd, m0_ack;
   logic [7:0] m1_addr, m1_wdat, m1_rdat;
   logic       m1_wr, m1_rd, m1_ack;
   logic [7:0] reg_addr, reg_wdat, reg_rdat;
   logic       reg_wr, reg_rd;
   wire        reg_ack;
   logic [1:0] gnt;
   logic       err, err_clr;
   logic       ack_en, force_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign reg_ack = ack_en ? (reg_wr | reg_rd) : force_ack;

   rtmc_reg_arb #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .m0_addr(m0_addr), .m0_wdat(m0_wdat), .m0_wr(m0_wr), .m0_rd(m0_rd),
      .m0_rdat(m0_rdat), .m0_ack(m0_ack),
      .m1_addr(m1_addr), .m1_wdat(m1_wdat), .m1_wr(m1_wr), .m1_rd(m1_rd),
      .m1_rdat(m1_rdat), .m1_ack(m1_ack),
      .reg_addr(reg_addr), .reg_wdat(reg_wdat), .reg_wr(reg_wr),
      .reg_rd(reg_rd), .reg_rdat(reg_rdat), .reg_ack(reg_ack),
      .gnt(gnt), .err(err), .err_clr(err_clr)
   );

   task automatic do_reset;
      rst = 1'b1;
      m0_addr = 0; m0_wdat = 0; m0_wr = 0; m0_rd = 0;
      m1_addr = 0; m1_wdat = 0; m1_wr = 0; m1_rd = 0;
      reg_rdat = 0; err_clr = 0; ack_en = 0; force_ack = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      checks++;
      if ({reg_wr, reg_rd, m0_ack, m1_ack, err} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_strobes got %b expected 00000", {reg_wr, reg_rd, m0_ack, m1_ack, err});
      end
      checks++;
      if (gnt !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_gnt got %b expected 00", gnt);
      end
      checks++;
      if ({reg_addr, reg_wdat, m0_rdat, m1_rdat} !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_data got %h expected 0", {reg_addr, reg_wdat, m0_rdat, m1_rdat});
      end
   endtask

   task automatic test_single_read;
      do_reset();
      m0_rd = 1; m0_addr = 8'h05; reg_rdat = 8'hA5; ack_en = 1;
      @(negedge clk);
      checks++;
      if ({reg_rd, reg_wr, gnt, m0_ack} !== 5'b10010) begin
         errors++;
         $display("[TB] FAIL read_strobe got rd/wr/gnt/ack %b expected 10010", {reg_rd, reg_wr, gnt, m0_ack});
      end
      checks++;
      if (reg_addr !== 8'h05) begin
         errors++;
         $display("[TB] FAIL read_addr got %h expected 05", reg_addr);
      end
      @(negedge clk);
      checks++;
      if ({reg_rd, m0_ack, gnt, m1_ack} !== 5'b01010) begin
         errors++;
         $display("[TB] FAIL read_ack got rd/ack/gnt/m1ack %b expected 01010", {reg_rd, m0_ack, gnt, m1_ack});
      end
      checks++;
      if (m0_rdat !== 8'hA5) begin
         errors++;
         $display("[TB] FAIL read_data got %h expected a5", m0_rdat);
      end
      m0_rd = 0;
      @(negedge clk);
      checks++;
      if ({m0_ack, gnt, m0_rdat} !== 11'b0) begin
         errors++;
         $display("[TB] FAIL read_done got ack/gnt/rdat %b expected 0", {m0_ack, gnt, m0_rdat});
      end
   endtask

   task automatic test_contention;
      int exp_m1;
      bit seen;
      do_reset();
      m0_wr = 1; m0_addr = 8'h10; m0_wdat = 8'h11;
      m1_wr = 1; m1_addr = 8'h20; m1_wdat = 8'h22;
      reg_rdat = 8'h77; ack_en = 1;
      @(negedge clk);
      checks++;
      if ({gnt, reg_wr, reg_addr, reg_wdat} !== {2'b01, 1'b1, 8'h10, 8'h11}) begin
         errors++;
         $display("[TB] FAIL contend_first got gnt/wr/addr/wdat %b/%b/%h/%h expected 01/1/10/11", gnt, reg_wr, reg_addr, reg_wdat);
      end
      for (int t = 0; t < 4; t++) begin
         exp_m1 = t % 2;
         seen = 0;
         for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) seen = 1;
         end
         checks++;
         if (!seen) begin
            errors++;
            $display("[TB] FAIL contend_wait txn %0d got no ack expected ack within 10 cycles", t);
         end else begin
            checks++;
            if ({m1_ack, m0_ack} !== (exp_m1 ? 2'b10 : 2'b01)) begin
               errors++;
               $display("[TB] FAIL contend_order txn %0d got acks %b expected %b", t, {m1_ack, m0_ack}, exp_m1 ? 2'b10 : 2'b01);
            end
            checks++;
            if ({m0_rdat, m1_rdat} !== 16'h0) begin
               errors++;
               $display("[TB] FAIL contend_wrdat txn %0d got %h expected 0000", t, {m0_rdat, m1_rdat});
            end
         end
      end
      m0_wr = 0; m1_wr = 0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({gnt, reg_wr} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL contend_idle got gnt/wr %b expected 000", {gnt, reg_wr});
      end
   endtask

   task automatic test_timeout;
      bit early;
      do_reset();
      m1_rd = 1; m1_addr = 8'h3A; reg_rdat = 8'h12;
      @(negedge clk);
      checks++;
      if ({gnt, reg_rd, reg_addr} !== {2'b10, 1'b1, 8'h3A}) begin
         errors++;
         $display("[TB] FAIL timeout_grant got gnt/rd/addr %b/%b/%h expected 10/1/3a", gnt, reg_rd, reg_addr);
      end
      early = 0;
      for (int i = 2; i <= 16; i++) begin
         @(negedge clk);
         if (m1_ack || err) early = 1;
      end
      checks++;
      if (early) begin
         errors++;
         $display("[TB] FAIL timeout_early got ack/err before 16 busy cycles expected none");
      end
      err_clr = 1;
      @(negedge clk);
      checks++;
      if ({m1_ack, m0_ack, err, reg_rd} !== 4'b1010) begin
         errors++;
         $display("[TB] FAIL timeout_ack got m1ack/m0ack/err/rd %b expected 1010", {m1_ack, m0_ack, err, reg_rd});
      end
      checks++;
      if (m1_rdat !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL timeout_rdat got %h expected ff", m1_rdat);
      end
      err_clr = 0; m1_rd = 0;
      @(negedge clk);
      checks++;
      if ({m1_ack, gnt, err} !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL timeout_sticky got ack/gnt/err %b expected 0001", {m1_ack, gnt, err});
      end
      err_clr = 1;
      @(negedge clk);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL err_clear got %b expected 0", err);
      end
      err_clr = 0; force_ack = 1;
      @(negedge clk);
      force_ack = 0;
      @(negedge clk);
      checks++;
      if ({m0_ack, m1_ack, gnt, err} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL late_ack got acks/gnt/err %b expected 00000", {m0_ack, m1_ack, gnt, err});
      end
   endtask

   task automatic test_reset_mid_busy;
      do_reset();
      m0_wr = 1; m0_rd = 1; m0_wdat = 8'h3C; m0_addr = 8'h44;
      @(negedge clk);
      checks++;
      if ({reg_wr, reg_rd, reg_wdat, reg_addr} !== {1'b1, 1'b0, 8'h3C, 8'h44}) begin
         errors++;
         $display("[TB] FAIL wr_rd_both got wr/rd/wdat/addr %b/%b/%h/%h expected 1/0/3c/44", reg_wr, reg_rd, reg_wdat, reg_addr);
      end
      rst = 1;
      @(negedge clk);
      checks++;
      if ({reg_wr, reg_rd, gnt, m0_ack, reg_wdat, reg_addr} !== 21'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset got wr/rd/gnt/ack/wdat/addr %b expected 0", {reg_wr, reg_rd, gnt, m0_ack, reg_wdat, reg_addr});
      end
      rst = 0; m0_wr = 0; m0_rd = 0;
      @(negedge clk);
      checks++;
      if ({m0_ack, gnt} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL mid_reset_noack got ack/gnt %b expected 000", {m0_ack, gnt});
      end
      m0_rd = 1; m1_rd = 1; ack_en = 1; reg_rdat = 8'h9C;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("[TB] FAIL post_reset_gnt got %b expected 01", gnt);
      end
      @(negedge clk);
      checks++;
      if ({m0_ack, m1_ack, m0_rdat} !== {2'b10, 8'h9C}) begin
         errors++;
         $display("[TB] FAIL post_reset_ack got ack0/ack1/rdat %b/%b/%h expected 1/0/9c", m0_ack, m1_ack, m0_rdat);
      end
      m0_rd = 0; m1_rd = 0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_ack_timeout_collision;
      do_reset();
      m0_rd = 1; m0_addr = 8'h33; reg_rdat = 8'h5A;
      for (int i = 1; i <= 16; i++) @(negedge clk);
      checks++;
      if ({m0_ack, reg_rd} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL collide_pre got ack/rd %b expected 01", {m0_ack, reg_rd});
      end
      force_ack = 1;
      @(negedge clk);
      checks++;
      if ({m0_ack, err, m0_rdat} !== {1'b1, 1'b0, 8'h5A}) begin
         errors++;
         $display("[TB] FAIL collide_ack got ack/err/rdat %b/%b/%h expected 1/0/5a", m0_ack, err, m0_rdat);
      end
      force_ack = 0; m0_rd = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_contention();
      test_timeout();
      test_reset_mid_busy();
      test_ack_timeout_collision();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
